// File: rtl/cpu_step_controller.sv
// cpu_step_controller: turns raw step/run buttons into single-clock step_pulse
// strobes for the program counter, with manual step, free-run and halt modes.
// Optional feature macro: CPU_BREAKPOINT_EN (stop in RUN when pc_address
// matches an armed bp_addr at the divider terminal, before that instruction).
module cpu_step_controller #(
    parameter int DEBOUNCE_LIMIT = 50000,
    parameter int RUN_DIV        = 10000000,
    parameter int PC_W           = 5,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc_address,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             step_pulse,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int DB_W  = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int DIV_W = $clog2(RUN_DIV);

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_LIMIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, state_d;

    // Bit 0 carries the step button, bit 1 the run button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      db_lvl;
    logic [1:0]      db_lvl_q;
    logic [DB_W-1:0] db_cnt [2];

    logic             step_press;
    logic             run_press;
    logic             bp_match;
    logic             div_term;
    logic             pulse_d;
    logic [DIV_W-1:0] div_cnt;

    assign btn_raw = {run_btn, step_btn};

    // Synchronise each button, then require DEBOUNCE_LIMIT consecutive high
    // cycles before the debounced level rises; any low sample restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_lvl   <= '0;
            db_lvl_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a   <= btn_raw;
            sync_b   <= sync_a;
            db_lvl_q <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (!sync_b[i]) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= 1'b0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                    if (db_cnt[i] == DB_MAX - 1'b1) begin
                        db_lvl[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // One-cycle press strobes from the rising edge of each debounced level.
    assign step_press = db_lvl[0] & ~db_lvl_q[0];
    assign run_press  = db_lvl[1] & ~db_lvl_q[1];

`ifdef CPU_BREAKPOINT_EN
    assign bp_match = bp_valid && (pc_address == bp_addr);
`else
    // Breakpoint ports stay on the boundary but feed nothing in this build.
    logic unused_bp;
    assign unused_bp = ^{bp_valid, bp_addr, pc_address};
    assign bp_match  = 1'b0;
`endif

    assign div_term = (state == RUN) && (div_cnt == DIV_LAST);

    // Rate divider: runs only while staying in RUN, so every entry starts at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if ((state != RUN) || (state_d != RUN)) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and pulse request; the if-chains encode event priority
    // halt_req > breakpoint > run press > step press / divider terminal.
    always_comb begin
        state_d = state;
        pulse_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (run_press) begin
                    state_d = RUN;
                end else if (step_press) begin
                    pulse_d = 1'b1;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (div_term && bp_match) begin
                    state_d = HALT;
                end else if (run_press) begin
                    state_d = IDLE;
                end else if (div_term) begin
                    pulse_d = 1'b1;
                end
            end
            HALT: begin
                if (!halt_req && step_press) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, updated on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_pulse <= 1'b0;
            running    <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            step_pulse <= pulse_d;
            running    <= (state_d == RUN);
            halted     <= (state_d == HALT);
            if (pulse_d && (step_count != CNT_MAX)) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Testbench for cpu_step_controller with DEBOUNCE_LIMIT=4, RUN_DIV=8, CNT_W=4.
// Expected step_pulse cycles are queued as stimulus is applied and popped by a
// monitor whenever the DUT pulses. Breakpoint steps need CPU_BREAKPOINT_EN.
module tb_cpu_step_controller;

    localparam int PC_W  = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             step_btn;
    logic             run_btn;
    logic             halt_req;
    logic [PC_W-1:0]  pc_address;
    logic [PC_W-1:0]  bp_addr;
    logic             bp_valid;
    logic             step_pulse;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] step_count;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int exp_total = 0;
    int exp_q[$];

    cpu_step_controller #(
        .DEBOUNCE_LIMIT(4),
        .RUN_DIV       (8),
        .PC_W          (PC_W),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .step_btn  (step_btn),
        .run_btn   (run_btn),
        .halt_req  (halt_req),
        .pc_address(pc_address),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .step_pulse(step_pulse),
        .running   (running),
        .halted    (halted),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse must match the oldest queued expectation, cycle for cycle.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: pulse at cycle %0d, required none", cyc);
            end
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                checks++;
                assert (cyc === e) else begin
                    errors++;
                    $error("FAIL pulse_cycle: pulse at cycle %0d, required %0d", cyc, e);
                end
            end
`ifdef CPU_BREAKPOINT_EN
            pc_address = pc_address + 1'b1;
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push_one(input int c);
        exp_q.push_back(c);
        exp_total++;
    endtask

    // Queue one pulse per divider terminal cycle in [first_term, last_term].
    task automatic push_pulses(input int first_term, input int last_term);
        for (int c = first_term; c <= last_term; c += 8) push_one(c + 1);
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b, required %b", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] got);
        logic [CNT_W-1:0] exp;
        exp = (exp_total > 15) ? 4'd15 : CNT_W'(exp_total);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: %0d pulses missing, required 0", tag, exp_q.size());
        end
    endtask

    initial begin
        int k;
        int m;
        int t;
        reset_n    = 1'b0;
        step_btn   = 1'b0;
        run_btn    = 1'b0;
        halt_req   = 1'b0;
        pc_address = '0;
        bp_addr    = '0;
        bp_valid   = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state, then idle with no buttons.
        check_bit("reset_pulse", step_pulse, 1'b0);
        check_bit("reset_running", running, 1'b0);
        check_bit("reset_halted", halted, 1'b0);
        check_cnt("reset_count", step_count);
        tick(50);
        check_cnt("idle_count", step_count);
        check_bit("idle_running", running, 1'b0);
        check_bit("idle_halted", halted, 1'b0);

        // Long step press: exactly one pulse, 7 cycles after the rise.
        k = cyc;
        push_one(k + 7);
        step_btn = 1'b1;
        tick(20);
        step_btn = 1'b0;
        tick(10);
        check_cnt("step_count_1", step_count);
        check_drained("step_pulse_seen");

        // Two 3-cycle glitches never reach the debounce limit.
        step_btn = 1'b1; tick(3);
        step_btn = 1'b0; tick(2);
        step_btn = 1'b1; tick(3);
        step_btn = 1'b0; tick(15);
        check_cnt("glitch_count", step_count);

        // Free run, stopped by a second run press landing on a terminal cycle.
        k = cyc;
        m = k + 40;
        push_pulses(k + 14, m + 5);
        run_btn = 1'b1;
        tick(10);
        run_btn = 1'b0;
        check_bit("run_running", running, 1'b1);
        wait_to(m);
        run_btn = 1'b1;
        wait_to(m + 6);
        check_bit("run_still_running", running, 1'b1);
        tick(1);
        check_bit("run_stopped", running, 1'b0);
        wait_to(m + 10);
        run_btn = 1'b0;
        tick(20);
        check_drained("run_pulses_seen");
        check_cnt("run_count", step_count);

        // halt_req on a terminal cycle suppresses that pulse and enters HALT.
        k = cyc;
        t = k + 30;
        push_pulses(k + 14, t - 1);
        run_btn = 1'b1;
        tick(10);
        run_btn = 1'b0;
        wait_to(t);
        halt_req = 1'b1;
        tick(1);
        check_bit("halt_halted", halted, 1'b1);
        check_bit("halt_running", running, 1'b0);
        tick(3);
        step_btn = 1'b1;
        tick(8);
        step_btn = 1'b0;
        tick(2);
        check_bit("halt_held", halted, 1'b1);
        halt_req = 1'b0;
        tick(2);
        k = cyc;
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        wait_to(k + 8);
        check_bit("halt_exit", halted, 1'b0);
        check_bit("halt_exit_running", running, 1'b0);
        tick(5);
        check_drained("halt_pulses_seen");
        check_cnt("halt_count", step_count);

`ifdef CPU_BREAKPOINT_EN
        // Breakpoint at PC 3: pulses for PCs 0..2, then HALT without executing 3.
        pc_address = '0;
        bp_addr    = 5'd3;
        bp_valid   = 1'b1;
        k = cyc;
        push_pulses(k + 14, k + 30);
        run_btn = 1'b1;
        tick(10);
        run_btn = 1'b0;
        wait_to(k + 39);
        check_bit("bp_halted", halted, 1'b1);
        checks++;
        assert (pc_address === 5'd3) else begin
            errors++;
            $error("FAIL bp_pc: got %0d, required 3", pc_address);
        end
        k = cyc;
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        wait_to(k + 8);
        check_bit("bp_exit", halted, 1'b0);
        tick(5);
        // Manual step at the breakpoint address is not blocked.
        k = cyc;
        push_one(k + 7);
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        tick(10);
        check_drained("bp_pulses_seen");
        check_cnt("bp_count", step_count);
        bp_valid = 1'b0;
`endif

        // Long run pushes the total past 20 pulses; count saturates at 15.
        k = cyc;
        m = k + 130;
        push_pulses(k + 14, m + 5);
        run_btn = 1'b1;
        tick(10);
        run_btn = 1'b0;
        wait_to(m);
        run_btn = 1'b1;
        tick(10);
        run_btn = 1'b0;
        tick(20);
        check_drained("sat_pulses_seen");
        check_cnt("sat_count", step_count);
        check_bit("sat_count_is_15", (step_count == 4'd15), 1'b1);

        // Reset mid-divide discards the partial count; no pulse afterwards.
        k = cyc;
        push_one(k + 15);
        run_btn = 1'b1;
        tick(10);
        run_btn = 1'b0;
        wait_to(k + 18);
        reset_n = 1'b0;
        exp_total = 0;
        tick(1);
        check_bit("rst_div_running", running, 1'b0);
        check_bit("rst_div_pulse", step_pulse, 1'b0);
        check_cnt("rst_div_count", step_count);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check_bit("rst_div_idle", running, 1'b0);

        // Reset mid-debounce: the partial press is forgotten.
        step_btn = 1'b1;
        tick(4);
        reset_n  = 1'b0;
        step_btn = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check_cnt("rst_db_count", step_count);
        check_bit("rst_db_halted", halted, 1'b0);
        check_drained("final_queue");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
